// File: rtl/fifo_prefetch_frame_reader.sv
// Read-domain frame reader for the prefetch FIFO: drains one frame of N samples
// per start onto a registered valid/ready stream with SOF/EOF, busy, done and underrun count.
module fifo_prefetch_frame_reader #(
    parameter int unsigned DATA_WIDTH     = 11,
    parameter int unsigned LEN_WIDTH      = 14,
    parameter int unsigned UNDERRUN_WIDTH = 16
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [LEN_WIDTH-1:0]      cfg_frame_len,
    input  logic                      fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    output logic                      fifo_rd_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_sof,
    output logic                      m_eof,
    output logic                      busy,
    output logic                      done,
    output logic [UNDERRUN_WIDTH-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [LEN_WIDTH-1:0]      r_len;
    logic [LEN_WIDTH-1:0]      r_cnt;
    logic                      r_m_valid;
    logic [DATA_WIDTH-1:0]     r_m_data;
    logic                      r_m_sof;
    logic                      r_m_eof;
    logic                      r_done;
    logic [UNDERRUN_WIDTH-1:0] r_underrun;

    logic                      w_slot_free;
    logic                      w_start_ok;
    logic                      w_pop;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_starve;

    // Output slot can take a new word when empty or being drained this cycle
    assign w_slot_free = !r_m_valid || m_ready;
    assign w_start_ok  = (r_state == S_IDLE) && start && !abort && (cfg_frame_len != '0);
    assign w_pop       = (r_state == S_RUN) && fifo_rd_vld && w_slot_free && !abort;
    assign w_last      = (r_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_accept    = r_m_valid && m_ready;
    assign w_starve    = (r_state == S_RUN) && w_slot_free && !fifo_rd_vld && !abort;

    assign fifo_rd_en   = w_pop;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_sof        = r_m_sof;
    assign m_eof        = r_m_eof;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign underrun_cnt = r_underrun;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok)       w_state_nxt = S_RUN;
                S_RUN:   if (w_pop && w_last)  w_state_nxt = S_FLUSH;
                S_FLUSH: if (w_accept)         w_state_nxt = S_IDLE;
                default:                       w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output register, sample counter, done pulse and underrun counter
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_sof    <= 1'b0;
            r_m_eof    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= '0;
        end else begin
            r_done <= (r_state == S_FLUSH) && w_accept && !abort;

            if (w_start_ok) begin
                r_len      <= cfg_frame_len;
                r_cnt      <= '0;
                r_underrun <= '0;
            end else if (w_starve && (r_underrun != '1)) begin
                r_underrun <= r_underrun + UNDERRUN_WIDTH'(1);
            end

            if (abort) begin
                r_m_valid <= 1'b0;
                r_m_sof   <= 1'b0;
                r_m_eof   <= 1'b0;
            end else if (w_pop) begin
                r_m_data  <= fifo_rd_data;
                r_m_valid <= 1'b1;
                r_m_sof   <= (r_cnt == '0);
                r_m_eof   <= w_last;
                r_cnt     <= r_cnt + LEN_WIDTH'(1);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_prefetch_frame_reader.sv
// Directed bench for fifo_prefetch_frame_reader with a queue-based prefetch FIFO
// and a log of accepted beats checked against hand-computed frames.
module tb_fifo_prefetch_frame_reader;

    localparam int unsigned DW = 11;
    localparam int unsigned LW = 14;
    localparam int unsigned UW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          start;
    logic          abort;
    logic [LW-1:0] cfg_frame_len;
    logic          fifo_rd_vld;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eof;
    logic          busy;
    logic          done;
    logic [UW-1:0] underrun_cnt;

    fifo_prefetch_frame_reader #(
        .DATA_WIDTH    (DW),
        .LEN_WIDTH     (LW),
        .UNDERRUN_WIDTH(UW)
    ) u_dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_frame_len(cfg_frame_len),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .busy         (busy),
        .done         (done),
        .underrun_cnt (underrun_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_viol;
    int n_done;
    int n_busy;
    int cyc_no   = 0;
    int done_cyc;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] bd[$];
    logic          bs[$];
    logic          be[$];
    int            bc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        bd.delete(); bs.delete(); be.delete(); bc.delete();
        n_viol = 0; n_done = 0; n_busy = 0; done_cyc = -1;
    endtask

    task automatic preload(input int first, input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(DW'(first + i));
    endtask

    // One clock: drive at negedge, sample 1ns later, pop the FIFO model if the DUT pops
    task automatic cyc(input logic st, input logic ab, input logic rdy);
        @(negedge rd_clk);
        start        = st;
        abort        = ab;
        m_ready      = rdy;
        fifo_rd_vld  = (fq.size() != 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
        #1;
        cyc_no++;
        if (fifo_rd_en && m_valid && !m_ready) n_viol++;
        if (fifo_rd_en && !fifo_rd_vld) n_viol++;
        if (m_valid && m_ready) begin
            bd.push_back(m_data); bs.push_back(m_sof); be.push_back(m_eof); bc.push_back(cyc_no);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_no;
        end
        if (busy) n_busy++;
        if (fifo_rd_en) void'(fq.pop_front());
    endtask

    task automatic check_seq(input string tag, input int first, input int n);
        check_eq({tag, "_beats"}, 32'(bd.size()), 32'(n));
        for (int i = 0; i < n && i < bd.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), 32'(bd[i]), 32'(DW'(first + i)));
            check_eq($sformatf("%s_sof%0d", tag, i), 32'(bs[i]), 32'(i == 0));
            check_eq($sformatf("%s_eof%0d", tag, i), 32'(be[i]), 32'(i == n - 1));
        end
    endtask

    task automatic run_frame8(input string tag);
        preload(1, 9);
        cfg_frame_len = LW'(8);
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1);
        check_seq(tag, 1, 8);
        if (bc.size() == 8) check_eq({tag, "_span"}, 32'(bc[7] - bc[0]), 32'd7);
        if (bc.size() == 8) check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'(bc[7] + 1));
        check_eq({tag, "_done_cnt"}, 32'(n_done), 32'd1);
        check_eq({tag, "_underrun"}, 32'(underrun_cnt), 32'd0);
        check_eq({tag, "_fifo_left"}, 32'(fq.size()), 32'd1);
        if (fq.size() == 1) check_eq({tag, "_fifo_word9"}, 32'(fq[0]), 32'h009);
        check_eq({tag, "_viol"}, 32'(n_viol), 32'd0);
    endtask

    initial begin
        rd_rst_n      = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        m_ready       = 1'b0;
        cfg_frame_len = '0;
        fifo_rd_vld   = 1'b0;
        fifo_rd_data  = '0;
        #12;
        check_eq("rst_m_valid",  32'(m_valid), 32'd0);
        check_eq("rst_m_data",   32'(m_data), 32'd0);
        check_eq("rst_sof_eof",  32'({m_sof, m_eof}), 32'd0);
        check_eq("rst_busy",     32'(busy), 32'd0);
        check_eq("rst_done",     32'(done), 32'd0);
        check_eq("rst_underrun", 32'(underrun_cnt), 32'd0);
        check_eq("rst_rd_en",    32'(fifo_rd_en), 32'd0);
        @(negedge rd_clk);
        rd_rst_n = 1'b1;

        // Back-to-back frame of 8 with ready held high
        run_frame8("s1");

        // Same frame under a 1,0,0,1 ready pattern
        preload(1, 8);
        cfg_frame_len = LW'(8);
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, ((i % 4) == 0) || ((i % 4) == 3));
        check_seq("s2", 1, 8);
        check_eq("s2_done_cnt", 32'(n_done), 32'd1);
        check_eq("s2_viol", 32'(n_viol), 32'd0);
        check_eq("s2_fifo_left", 32'(fq.size()), 32'd0);

        // Starved frame: 2 words present, words 3 and 4 arrive later
        preload(12'h0A1, 2);
        cfg_frame_len = LW'(4);
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 20; i++) begin
            if (i == 7) begin
                fq.push_back(DW'(12'h0A3));
                fq.push_back(DW'(12'h0A4));
            end
            cyc(1'b0, 1'b0, 1'b1);
        end
        check_seq("s3", 12'h0A1, 4);
        check_eq("s3_underrun", 32'(underrun_cnt), 32'd4);
        check_eq("s3_done_cnt", 32'(n_done), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        check_eq("s3_underrun_hold", 32'(underrun_cnt), 32'd4);

        // Single-sample frame, then a zero-length start
        preload(12'h0B1, 2);
        cfg_frame_len = LW'(1);
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);
        check_seq("s4", 12'h0B1, 1);
        check_eq("s4_done_cnt", 32'(n_done), 32'd1);
        check_eq("s4_fifo_left", 32'(fq.size()), 32'd1);
        cfg_frame_len = '0;
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);
        check_eq("s4z_busy_cycles", 32'(n_busy), 32'd0);
        check_eq("s4z_done_cnt", 32'(n_done), 32'd0);
        check_eq("s4z_beats", 32'(bd.size()), 32'd0);
        check_eq("s4z_fifo_left", 32'(fq.size()), 32'd1);

        // Abort after three accepted samples, then a length-2 frame
        preload(1, 8);
        cfg_frame_len = LW'(8);
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check_eq("s5_beats_before", 32'(bd.size()), 32'd3);
        cyc(1'b0, 1'b0, 1'b1);
        check_eq("s5_m_valid", 32'(m_valid), 32'd0);
        check_eq("s5_busy", 32'(busy), 32'd0);
        check_eq("s5_sof_eof", 32'({m_sof, m_eof}), 32'd0);
        check_eq("s5_done_cnt", 32'(n_done), 32'd0);
        clear_log();
        cfg_frame_len = LW'(2);
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);
        check_seq("s5b", 5, 2);
        check_eq("s5b_done_cnt", 32'(n_done), 32'd1);
        check_eq("s5b_fifo_left", 32'(fq.size()), 32'd2);

        // Asynchronous reset in the middle of a frame
        preload(1, 9);
        cfg_frame_len = LW'(8);
        clear_log();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        #2;
        rd_rst_n = 1'b0;
        #1;
        check_eq("s6_m_valid", 32'(m_valid), 32'd0);
        check_eq("s6_m_data", 32'(m_data), 32'd0);
        check_eq("s6_sof_eof", 32'({m_sof, m_eof}), 32'd0);
        check_eq("s6_busy", 32'(busy), 32'd0);
        check_eq("s6_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("s6_done", 32'(done), 32'd0);
        @(negedge rd_clk);
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        run_frame8("s6b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
